// File: rtl/axi_arb_pkg.sv
// Shared types and constants for the memory-side AXI read arbiter.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package axi_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } arb_state_e;

  localparam int MST_ICACHE = 0;
  localparam int MST_DCACHE = 1;
  localparam int MST_SB     = 2;

endpackage

// File: rtl/rr_picker.sv
// Rotating priority encoder: first asserted request at or after ptr, wrapping modulo N.
module rr_picker #(
  parameter int N = 3,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] grant_idx,
  output logic         grant_valid
);

  logic [W-1:0] idx;

  // Walk the offsets from farthest to nearest so the nearest hit is written last.
  always_comb begin
    grant_idx   = '0;
    grant_valid = 1'b0;
    idx         = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = W'((int'(ptr) + k) % N);
      if (req[idx]) begin
        grant_idx   = idx;
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axi_read_arbiter.sv
// Merges several AXI read masters onto one memory read port: one burst in flight,
// round-robin address grant, R beats steered back to the owning master.
module axi_read_arbiter
  import axi_arb_pkg::*;
#(
  parameter int NUM_MASTERS = 3,
  parameter int ADDR_W      = `ADDR_WIDTH,
  parameter int DATA_W      = `DATA_WIDTH,
  parameter int ID_W        = 4,
  parameter int LEN_W       = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_MASTERS-1:0]        m_arvalid,
  input  logic [NUM_MASTERS*ADDR_W-1:0] m_araddr,
  input  logic [NUM_MASTERS*LEN_W-1:0]  m_arlen,
  input  logic [NUM_MASTERS*ID_W-1:0]   m_arid,
  output logic [NUM_MASTERS-1:0]        m_arready,
  output logic [NUM_MASTERS-1:0]        m_rvalid,
  input  logic [NUM_MASTERS-1:0]        m_rready,
  output logic [DATA_W-1:0]             m_rdata,
  output logic                          m_rlast,
  output logic                          s_arvalid,
  output logic [ADDR_W-1:0]             s_araddr,
  output logic [LEN_W-1:0]              s_arlen,
  output logic [ID_W-1:0]               s_arid,
  input  logic                          s_arready,
  input  logic                          s_rvalid,
  input  logic [DATA_W-1:0]             s_rdata,
  input  logic                          s_rlast,
  input  logic [ID_W-1:0]               s_rid,
  output logic                          s_rready,
  output logic                          id_error
);

  localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  arb_state_e        state;
  logic [IDX_W-1:0]  rr_ptr;
  logic [IDX_W-1:0]  owner;
  logic [IDX_W-1:0]  grant_idx;
  logic              grant_valid;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  len_q;
  logic [ID_W-1:0]   id_q;
  logic              accept;
  logic              beat;

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
    return (int'(i) == NUM_MASTERS - 1) ? '0 : i + 1'b1;
  endfunction

  rr_picker #(.N(NUM_MASTERS), .W(IDX_W)) u_picker (
    .req         (m_arvalid),
    .ptr         (rr_ptr),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  // No address is accepted while reset is held, even though state already reads IDLE.
  assign accept = rst_n && (state == IDLE) && grant_valid;
  assign beat   = (state == DATA) && s_rvalid && s_rready;

  always_comb begin
    m_arready = '0;
    m_rvalid  = '0;
    if (accept)
      m_arready[grant_idx] = 1'b1;
    if (state == DATA)
      m_rvalid[owner] = s_rvalid;
  end

  assign s_rready  = (state == DATA) && m_rready[owner];
  assign m_rdata   = s_rdata;
  assign m_rlast   = s_rlast;
  assign s_arvalid = (state == ADDR);
  assign s_araddr  = addr_q;
  assign s_arlen   = len_q;
  assign s_arid    = id_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      owner    <= '0;
      addr_q   <= '0;
      len_q    <= '0;
      id_q     <= '0;
      id_error <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_valid) begin
            owner  <= grant_idx;
            addr_q <= m_araddr[grant_idx*ADDR_W +: ADDR_W];
            len_q  <= m_arlen[grant_idx*LEN_W +: LEN_W];
            id_q   <= m_arid[grant_idx*ID_W +: ID_W];
            state  <= ADDR;
          end
        end
        ADDR: begin
          if (s_arready)
            state <= DATA;
        end
        DATA: begin
          // Beat count is not tracked; RLAST alone closes the burst.
          if (beat) begin
            if (s_rid != id_q)
              id_error <= 1'b1;
            if (s_rlast) begin
              state  <= IDLE;
              rr_ptr <= next_idx(owner);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Directed bench for axi_read_arbiter: grant order, address hold, beat routing, id check, reset.
module tb_axi_read_arbiter;

  localparam int NM = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int IW = 4;
  localparam int LW = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NM-1:0]    m_arvalid;
  logic [NM*AW-1:0] m_araddr;
  logic [NM*LW-1:0] m_arlen;
  logic [NM*IW-1:0] m_arid;
  logic [NM-1:0]    m_arready;
  logic [NM-1:0]    m_rvalid;
  logic [NM-1:0]    m_rready;
  logic [DW-1:0]    m_rdata;
  logic             m_rlast;
  logic             s_arvalid;
  logic [AW-1:0]    s_araddr;
  logic [LW-1:0]    s_arlen;
  logic [IW-1:0]    s_arid;
  logic             s_arready;
  logic             s_rvalid;
  logic [DW-1:0]    s_rdata;
  logic             s_rlast;
  logic [IW-1:0]    s_rid;
  logic             s_rready;
  logic             id_error;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  axi_read_arbiter #(
    .NUM_MASTERS(NM), .ADDR_W(AW), .DATA_W(DW), .ID_W(IW), .LEN_W(LW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .m_arvalid(m_arvalid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arid(m_arid),
    .m_arready(m_arready), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .m_rdata(m_rdata), .m_rlast(m_rlast),
    .s_arvalid(s_arvalid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arid(s_arid),
    .s_arready(s_arready), .s_rvalid(s_rvalid), .s_rdata(s_rdata), .s_rlast(s_rlast),
    .s_rid(s_rid), .s_rready(s_rready), .id_error(id_error)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Entered mid-cycle in IDLE with the request already driven; leaves mid-cycle back in IDLE.
  task automatic run_burst(input int m, input logic [31:0] addr, input logic [7:0] len,
                           input logic [3:0] id, input logic [3:0] rid, input bit hold,
                           input int late_m);
    m_araddr[m*AW +: AW] = addr;
    m_arlen[m*LW +: LW]  = len;
    m_arid[m*IW +: IW]   = id;
    #1 chk("grant_arready", m_arready, 3'b001 << m);
    @(posedge clk); #1;
    if (!hold) m_arvalid[m] = 1'b0;
    s_arready = 1'b1;
    #1;
    chk("addr_arvalid", s_arvalid, 1'b1);
    chk("addr_araddr", s_araddr, addr);
    chk("addr_arlen", s_arlen, len);
    chk("addr_arid", s_arid, id);
    chk("addr_arready_low", m_arready, 3'b000);
    @(posedge clk); #1;
    s_arready = 1'b0;
    for (int b = 0; b <= int'(len); b++) begin
      s_rvalid = 1'b1;
      s_rdata  = {addr[15:0], 8'h00, 8'(b)};
      s_rlast  = (b == int'(len));
      s_rid    = rid;
      if (b == 0 && late_m >= 0) m_arvalid[late_m] = 1'b1;
      #1;
      chk("beat_rvalid", m_rvalid, 3'b001 << m);
      chk("beat_rdata", m_rdata, {addr[15:0], 8'h00, 8'(b)});
      chk("beat_rlast", m_rlast, (b == int'(len)));
      chk("beat_s_rready", s_rready, 1'b1);
      chk("beat_arready_low", m_arready, 3'b000);
      @(posedge clk); #1;
    end
    s_rvalid = 1'b0;
    s_rlast  = 1'b0;
    #1;
    chk("idle_rvalid", m_rvalid, 3'b000);
    chk("idle_s_rready", s_rready, 1'b0);
    chk("idle_s_arvalid", s_arvalid, 1'b0);
  endtask

  initial begin
    rst_n     = 1'b0;
    m_arvalid = '0;
    m_araddr  = '0;
    m_arlen   = '0;
    m_arid    = '0;
    m_rready  = 3'b111;
    s_arready = 1'b0;
    s_rvalid  = 1'b0;
    s_rdata   = '0;
    s_rlast   = 1'b0;
    s_rid     = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_arready", m_arready, 3'b000);
    chk("rst_rvalid", m_rvalid, 3'b000);
    chk("rst_s_arvalid", s_arvalid, 1'b0);
    chk("rst_s_rready", s_rready, 1'b0);
    chk("rst_id_error", id_error, 1'b0);
    chk("rst_araddr", s_araddr, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single request from the stream buffer.
    m_arvalid = 3'b100;
    run_burst(2, 32'h100, 8'd3, 4'd2, 4'd2, 1'b0, -1);
    chk("single_rr", dut.rr_ptr, 2'd0);

    // Three persistent requesters: 0, 1, 2, 0.
    m_arvalid = 3'b111;
    run_burst(0, 32'h1000, 8'd1, 4'd0, 4'd0, 1'b1, -1);
    chk("cont_rr0", dut.rr_ptr, 2'd1);
    run_burst(1, 32'h2000, 8'd1, 4'd1, 4'd1, 1'b1, -1);
    chk("cont_rr1", dut.rr_ptr, 2'd2);
    run_burst(2, 32'h3000, 8'd1, 4'd2, 4'd2, 1'b1, -1);
    chk("cont_rr2", dut.rr_ptr, 2'd0);
    run_burst(0, 32'h4000, 8'd0, 4'd0, 4'd0, 1'b0, -1);
    m_arvalid = 3'b000;
    chk("cont_rr3", dut.rr_ptr, 2'd1);

    // rr_ptr=1 with masters 0 and 2 requesting: 2 first, then 0.
    m_arvalid = 3'b101;
    run_burst(2, 32'h5000, 8'd0, 4'd9, 4'd9, 1'b0, -1);
    chk("rr_skip_rr", dut.rr_ptr, 2'd0);
    run_burst(0, 32'h6000, 8'd0, 4'd3, 4'd3, 1'b0, -1);
    chk("rr_after0", dut.rr_ptr, 2'd1);

    // Address and read-data backpressure on a d-cache burst.
    m_arvalid = 3'b010;
    m_araddr[AW +: AW] = 32'h200;
    m_arlen[LW +: LW]  = 8'd3;
    m_arid[IW +: IW]   = 4'd5;
    #1 chk("bp_arready", m_arready, 3'b010);
    @(posedge clk); #1;
    m_arvalid = 3'b000;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_arvalid", s_arvalid, 1'b1);
      chk("bp_araddr", s_araddr, 32'h200);
      chk("bp_arlen", s_arlen, 8'd3);
      chk("bp_arid", s_arid, 4'd5);
      @(posedge clk); #1;
    end
    s_arready = 1'b1;
    #1 chk("bp_arvalid_last", s_arvalid, 1'b1);
    @(posedge clk); #1;
    s_arready = 1'b0;
    begin
      int b;
      b = 0;
      for (int cyc = 0; cyc < 6; cyc++) begin
        m_rready = (cyc == 1 || cyc == 2) ? 3'b101 : 3'b111;
        s_rvalid = 1'b1;
        s_rdata  = 32'hB000 + 32'(b);
        s_rlast  = (b == 3);
        s_rid    = 4'd5;
        #1;
        chk("bp_s_rready", s_rready, m_rready[1]);
        chk("bp_rvalid", m_rvalid, 3'b010);
        chk("bp_rdata", m_rdata, 32'hB000 + 32'(b));
        if (m_rready[1]) b++;
        @(posedge clk); #1;
      end
    end
    s_rvalid = 1'b0;
    s_rlast  = 1'b0;
    m_rready = 3'b111;
    #1;
    chk("bp_done_rvalid", m_rvalid, 3'b000);
    chk("bp_done_s_rready", s_rready, 1'b0);
    chk("bp_rr", dut.rr_ptr, 2'd2);

    // Master 0 raises a request during master 1's burst.
    m_arvalid = 3'b010;
    run_burst(1, 32'h7000, 8'd2, 4'd4, 4'd4, 1'b0, 0);
    chk("iso_rr", dut.rr_ptr, 2'd2);
    run_burst(0, 32'h8000, 8'd0, 4'd6, 4'd6, 1'b0, -1);
    chk("iso_rr0", dut.rr_ptr, 2'd1);

    // Response id mismatch is sticky across later bursts.
    chk("pre_id_error", id_error, 1'b0);
    m_arvalid = 3'b010;
    run_burst(1, 32'h9000, 8'd0, 4'd1, 4'd2, 1'b0, -1);
    chk("id_error_set", id_error, 1'b1);
    m_arvalid = 3'b100;
    run_burst(2, 32'hA000, 8'd1, 4'd3, 4'd3, 1'b0, -1);
    chk("id_error_sticky", id_error, 1'b1);
    chk("id_rr", dut.rr_ptr, 2'd0);
    m_arvalid = 3'b010;
    run_burst(1, 32'hA100, 8'd0, 4'd1, 4'd1, 1'b0, -1);
    chk("id_error_sticky2", id_error, 1'b1);
    chk("pre_rst_rr", dut.rr_ptr, 2'd2);

    // Reset after beat 1 of a 4-beat burst.
    m_arvalid = 3'b100;
    m_araddr[2*AW +: AW] = 32'h300;
    m_arlen[2*LW +: LW]  = 8'd3;
    m_arid[2*IW +: IW]   = 4'd7;
    #1 chk("mid_arready", m_arready, 3'b100);
    @(posedge clk); #1;
    m_arvalid = 3'b000;
    s_arready = 1'b1;
    #1 chk("mid_arvalid", s_arvalid, 1'b1);
    @(posedge clk); #1;
    s_arready = 1'b0;
    for (int b = 0; b < 2; b++) begin
      s_rvalid = 1'b1;
      s_rdata  = 32'hC0 + 32'(b);
      s_rlast  = 1'b0;
      s_rid    = 4'd7;
      #1 chk("mid_rvalid", m_rvalid, 3'b100);
      @(posedge clk); #1;
    end
    rst_n   = 1'b0;
    s_rdata = 32'hC2;
    @(posedge clk); #1;
    chk("mrst_rvalid", m_rvalid, 3'b000);
    chk("mrst_s_rready", s_rready, 1'b0);
    chk("mrst_s_arvalid", s_arvalid, 1'b0);
    chk("mrst_arready", m_arready, 3'b000);
    chk("mrst_id_error", id_error, 1'b0);
    chk("mrst_rr", dut.rr_ptr, 2'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("late_rvalid", m_rvalid, 3'b000);
      chk("late_s_rready", s_rready, 1'b0);
      @(posedge clk); #1;
    end
    s_rvalid  = 1'b0;
    m_arvalid = 3'b101;
    run_burst(0, 32'hD000, 8'd1, 4'd8, 4'd8, 1'b0, -1);
    chk("post_rst_rr", dut.rr_ptr, 2'd1);
    run_burst(2, 32'hE000, 8'd0, 4'd2, 4'd2, 1'b0, -1);
    chk("post_rst_rr2", dut.rr_ptr, 2'd0);
    chk("post_rst_id_error", id_error, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
